// File: rtl/wb_arbiter_wdt_pkg.sv
// Shared types for the Wishbone arbiter: FSM state encoding and the bit positions
// of the packed {rty, err, ack} termination vector.
package wb_arbiter_wdt_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StAbort  = 2'd2
  } state_e;

  localparam logic [2:0] TermAck = 3'b001;
  localparam logic [2:0] TermErr = 3'b010;
  localparam logic [2:0] TermRty = 3'b100;

endpackage

// File: rtl/wb_arb_select.sv
// Combinational request selector: fixed priority or round robin. In round-robin mode
// the search starts one past the last grantee.
module wb_arb_select #(
  parameter int unsigned PORTS                 = 4,
  parameter int unsigned ARB_TYPE_ROUND_ROBIN  = 1,
  parameter int unsigned ARB_LSB_HIGH_PRIORITY = 1
) (
  input  logic [PORTS-1:0] req_i,
  input  logic [PORTS-1:0] last_i,
  output logic [PORTS-1:0] grant_o,
  output logic             valid_o
);

  localparam int unsigned IdxW = (PORTS > 1) ? $clog2(PORTS) : 1;

  int unsigned last_idx;

  always_comb begin
    last_idx = 0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (last_i[i]) last_idx = i;
    end
  end

  always_comb begin
    int unsigned     pos;
    logic [IdxW-1:0] idx;
    logic            found;
    grant_o = '0;
    found   = 1'b0;
    pos     = 0;
    idx     = '0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      if (ARB_TYPE_ROUND_ROBIN != 0) begin
        // Adding 2*PORTS keeps the downward walk non-negative before the modulo.
        pos = (ARB_LSB_HIGH_PRIORITY != 0) ? (last_idx + 1 + k) % PORTS
                                           : (last_idx + 2 * PORTS - 1 - k) % PORTS;
      end else begin
        pos = (ARB_LSB_HIGH_PRIORITY != 0) ? k : PORTS - 1 - k;
      end
      idx = IdxW'(pos);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/wb_arbiter_wdt.sv
// Wishbone N:1 arbiter with registered, CYC-held grant and a bus watchdog that aborts
// strobed accesses the slave never terminates, returning a one-cycle ERR.
module wb_arbiter_wdt
  import wb_arbiter_wdt_pkg::*;
#(
  parameter int unsigned PORTS                 = 4,
  parameter int unsigned DATA_WIDTH            = 32,
  parameter int unsigned ADDR_WIDTH            = 32,
  parameter int unsigned SELECT_WIDTH          = DATA_WIDTH / 8,
  parameter int unsigned ARB_TYPE_ROUND_ROBIN  = 1,
  parameter int unsigned ARB_LSB_HIGH_PRIORITY = 1,
  parameter int unsigned TIMEOUT               = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS*ADDR_WIDTH-1:0]   wbm_adr_i,
  input  logic [PORTS*DATA_WIDTH-1:0]   wbm_dat_i,
  output logic [DATA_WIDTH-1:0]         wbm_dat_o,
  input  logic [PORTS-1:0]              wbm_we_i,
  input  logic [PORTS*SELECT_WIDTH-1:0] wbm_sel_i,
  input  logic [PORTS-1:0]              wbm_stb_i,
  input  logic [PORTS-1:0]              wbm_cyc_i,
  output logic [PORTS-1:0]              wbm_ack_o,
  output logic [PORTS-1:0]              wbm_err_o,
  output logic [PORTS-1:0]              wbm_rty_o,
  output logic [ADDR_WIDTH-1:0]         wbs_adr_o,
  output logic [DATA_WIDTH-1:0]         wbs_dat_o,
  input  logic [DATA_WIDTH-1:0]         wbs_dat_i,
  output logic                          wbs_we_o,
  output logic [SELECT_WIDTH-1:0]       wbs_sel_o,
  output logic                          wbs_stb_o,
  output logic                          wbs_cyc_o,
  input  logic                          wbs_ack_i,
  input  logic                          wbs_err_i,
  input  logic                          wbs_rty_i,
  output logic [PORTS-1:0]              grant_o,
  output logic                          timeout_o
);

  localparam int unsigned    WdtW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WdtW-1:0] WdtLast = (TIMEOUT > 0) ? WdtW'(TIMEOUT - 1) : '0;
  // Reset "last grantee" so that port 0 is searched first in either direction.
  localparam logic [PORTS-1:0] LastRst = (ARB_LSB_HIGH_PRIORITY != 0) ?
                                         (PORTS'(1) << (PORTS - 1)) : PORTS'(2);

  state_e            state_q, state_d;
  logic [PORTS-1:0]  grant_q, grant_d;
  logic [PORTS-1:0]  last_q, last_d;
  logic [WdtW-1:0]   wdt_q, wdt_d;

  logic [PORTS-1:0]        sel_grant;
  logic                    sel_valid;
  logic [ADDR_WIDTH-1:0]   adr_mux;
  logic [DATA_WIDTH-1:0]   dat_mux;
  logic [SELECT_WIDTH-1:0] sel_mux;
  logic                    we_mux, stb_mux, gnt_cyc, is_active, is_abort;
  logic [2:0]              term_vec;

  wb_arb_select #(
    .PORTS                 (PORTS),
    .ARB_TYPE_ROUND_ROBIN  (ARB_TYPE_ROUND_ROBIN),
    .ARB_LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
  ) u_select (
    .req_i   (wbm_cyc_i),
    .last_i  (last_q),
    .grant_o (sel_grant),
    .valid_o (sel_valid)
  );

  // AND-OR mux of the granted master; all zero when nothing is granted.
  always_comb begin
    adr_mux = '0;
    dat_mux = '0;
    sel_mux = '0;
    we_mux  = 1'b0;
    stb_mux = 1'b0;
    for (int unsigned n = 0; n < PORTS; n++) begin
      if (grant_q[n]) begin
        adr_mux |= wbm_adr_i[n*ADDR_WIDTH +: ADDR_WIDTH];
        dat_mux |= wbm_dat_i[n*DATA_WIDTH +: DATA_WIDTH];
        sel_mux |= wbm_sel_i[n*SELECT_WIDTH +: SELECT_WIDTH];
        we_mux  |= wbm_we_i[n];
        stb_mux |= wbm_stb_i[n];
      end
    end
  end

  assign is_active = (state_q == StActive);
  assign is_abort  = (state_q == StAbort);
  assign gnt_cyc   = |(wbm_cyc_i & grant_q);
  assign term_vec  = {wbs_rty_i, wbs_err_i, wbs_ack_i};

  assign wbs_adr_o = adr_mux;
  assign wbs_dat_o = dat_mux;
  assign wbs_sel_o = sel_mux;
  assign wbs_we_o  = we_mux;
  assign wbs_stb_o = is_active & stb_mux;
  assign wbs_cyc_o = is_active;
  assign wbm_dat_o = wbs_dat_i;

  assign wbm_ack_o = (is_active && |(term_vec & TermAck)) ? grant_q : '0;
  assign wbm_rty_o = (is_active && |(term_vec & TermRty)) ? grant_q : '0;
  assign wbm_err_o = ((is_active && |(term_vec & TermErr)) || is_abort) ? grant_q : '0;
  assign grant_o   = grant_q;
  assign timeout_o = is_abort;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wdt_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (sel_valid) begin
          grant_d = sel_grant;
          state_d = StActive;
        end
      end
      StActive: begin
        if (!gnt_cyc) begin
          grant_d = '0;
          last_d  = grant_q;
          state_d = StIdle;
        end else if (TIMEOUT != 0 && wbs_stb_o && !(|term_vec)) begin
          // A termination in the limit cycle takes the other branch, so it wins.
          if (wdt_q == WdtLast) state_d = StAbort;
          else                  wdt_d   = wdt_q + WdtW'(1);
        end
      end
      StAbort: begin
        if (!gnt_cyc) begin
          grant_d = '0;
          last_d  = grant_q;
          state_d = StIdle;
        end else begin
          state_d = StActive;
        end
      end
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= LastRst;
      wdt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wdt_q   <= wdt_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_wdt.sv
// Directed bench: round-robin/watchdog instance plus a fixed-priority, no-watchdog instance.
module tb_wb_arbiter_wdt;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] gnt;
  } arb_vec_t;

  typedef struct packed {
    logic [2:0] term;  // {rty, err, ack}
    logic [3:0] ack;
    logic [3:0] err;
    logic [3:0] rty;
  } term_vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] adr, dat_w;
  logic [3:0]   we, cyc, stb, cyc_fp, stb_fp;
  logic [15:0]  sel;
  logic [31:0]  s_dat_i;
  logic         s_ack, s_err, s_rty;

  logic [31:0] m_dat, s_adr, s_dat_o, m_dat_f, s_adr_f, s_dat_o_f;
  logic [3:0]  m_ack, m_err, m_rty, s_sel, gnt, m_ack_f, m_err_f, m_rty_f, s_sel_f, gnt_f;
  logic        s_we, s_stb, s_cyc, tmo, s_we_f, s_stb_f, s_cyc_f, tmo_f;

  int pass_cnt = 0;
  int total_cnt = 0;

  arb_vec_t  fp_vecs [5];
  term_vec_t t_vecs  [5];
  logic [3:0] rr_seq [4];

  always #5 clk = ~clk;

  wb_arbiter_wdt #(
    .PORTS(4), .DATA_WIDTH(32), .ADDR_WIDTH(32), .ARB_TYPE_ROUND_ROBIN(1),
    .ARB_LSB_HIGH_PRIORITY(1), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .wbm_adr_i(adr), .wbm_dat_i(dat_w), .wbm_dat_o(m_dat),
    .wbm_we_i(we), .wbm_sel_i(sel), .wbm_stb_i(stb), .wbm_cyc_i(cyc),
    .wbm_ack_o(m_ack), .wbm_err_o(m_err), .wbm_rty_o(m_rty),
    .wbs_adr_o(s_adr), .wbs_dat_o(s_dat_o), .wbs_dat_i(s_dat_i), .wbs_we_o(s_we),
    .wbs_sel_o(s_sel), .wbs_stb_o(s_stb), .wbs_cyc_o(s_cyc), .wbs_ack_i(s_ack),
    .wbs_err_i(s_err), .wbs_rty_i(s_rty), .grant_o(gnt), .timeout_o(tmo)
  );

  wb_arbiter_wdt #(
    .PORTS(4), .DATA_WIDTH(32), .ADDR_WIDTH(32), .ARB_TYPE_ROUND_ROBIN(0),
    .ARB_LSB_HIGH_PRIORITY(1), .TIMEOUT(0)
  ) dut_fp (
    .clk(clk), .rst(rst), .wbm_adr_i(adr), .wbm_dat_i(dat_w), .wbm_dat_o(m_dat_f),
    .wbm_we_i(we), .wbm_sel_i(sel), .wbm_stb_i(stb_fp), .wbm_cyc_i(cyc_fp),
    .wbm_ack_o(m_ack_f), .wbm_err_o(m_err_f), .wbm_rty_o(m_rty_f),
    .wbs_adr_o(s_adr_f), .wbs_dat_o(s_dat_o_f), .wbs_dat_i(s_dat_i), .wbs_we_o(s_we_f),
    .wbs_sel_o(s_sel_f), .wbs_stb_o(s_stb_f), .wbs_cyc_o(s_cyc_f), .wbs_ack_i(s_ack),
    .wbs_err_i(s_err), .wbs_rty_i(s_rty), .grant_o(gnt_f), .timeout_o(tmo_f)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic saw;
    fp_vecs[0] = '{req: 4'b1010, gnt: 4'b0010};
    fp_vecs[1] = '{req: 4'b1000, gnt: 4'b1000};
    fp_vecs[2] = '{req: 4'b1111, gnt: 4'b0001};
    fp_vecs[3] = '{req: 4'b0110, gnt: 4'b0010};
    fp_vecs[4] = '{req: 4'b1100, gnt: 4'b0100};
    t_vecs[0]  = '{term: 3'b000, ack: 4'b0000, err: 4'b0000, rty: 4'b0000};
    t_vecs[1]  = '{term: 3'b001, ack: 4'b0001, err: 4'b0000, rty: 4'b0000};
    t_vecs[2]  = '{term: 3'b010, ack: 4'b0000, err: 4'b0001, rty: 4'b0000};
    t_vecs[3]  = '{term: 3'b100, ack: 4'b0000, err: 4'b0000, rty: 4'b0001};
    t_vecs[4]  = '{term: 3'b011, ack: 4'b0001, err: 4'b0001, rty: 4'b0000};
    rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b1000; rr_seq[3] = 4'b0001;

    rst = 1'b1; adr = '0; dat_w = '0; we = '0; sel = '0; cyc = '0; stb = '0;
    cyc_fp = '0; stb_fp = '0; s_dat_i = '0; s_ack = 0; s_err = 0; s_rty = 0;
    #12;
    check("rst_gnt", gnt, 0);
    check("rst_cyc", s_cyc, 0);
    check("rst_tmo", tmo, 0);
    check("rst_gnt_fp", gnt_f, 0);
    @(negedge clk) rst = 1'b0;
    tick();

    // Fixed priority, port 0 highest
    for (int i = 0; i < 5; i++) begin
      cyc_fp = fp_vecs[i].req; stb_fp = fp_vecs[i].req;
      tick();
      check("fp_gnt", gnt_f, fp_vecs[i].gnt);
      check("fp_cyc", s_cyc_f, 1);
      cyc_fp = '0; stb_fp = '0;
      tick();
      check("fp_release", gnt_f, 0);
    end

    // Ports 1 and 3 together; port 3 waits for port 1 to drop; no watchdog with TIMEOUT=0
    cyc_fp = 4'b1010; stb_fp = 4'b1010;
    tick();
    check("fp13_first", gnt_f, 4'b0010);
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (tmo_f || m_err_f != 0) saw = 1'b1;
    end
    check("fp13_held", gnt_f, 4'b0010);
    check("fp_no_wdt", saw, 0);
    cyc_fp = 4'b1000; stb_fp = 4'b1000;
    tick();
    check("fp13_dead", gnt_f, 0);
    tick();
    check("fp13_second", gnt_f, 4'b1000);
    cyc_fp = '0; stb_fp = '0;
    tick();

    // Round robin among ports 0,1,3
    cyc = 4'b1011; stb = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_gnt", gnt, rr_seq[i]);
      s_ack = 1'b1;
      #1;
      check("rr_ack", m_ack, rr_seq[i]);
      tick();
      s_ack = 1'b0;
      cyc = cyc & ~rr_seq[i]; stb = stb & ~rr_seq[i];
      tick();
      check("rr_idle", gnt, 0);
      cyc = cyc | rr_seq[i]; stb = stb | rr_seq[i];
    end
    cyc = '0; stb = '0;
    tick();

    // Single read from port 2
    adr[64 +: 32] = 32'h1000; sel[8 +: 4] = 4'hf;
    cyc = 4'b0100; stb = 4'b0100;
    tick();
    check("sr_cyc", s_cyc, 1);
    check("sr_stb", s_stb, 1);
    check("sr_adr", s_adr, 32'h1000);
    check("sr_sel", s_sel, 4'hf);
    check("sr_gnt", gnt, 4'b0100);
    for (int i = 0; i < 2; i++) begin
      check("sr_noack", m_ack, 0);
      tick();
    end
    s_ack = 1'b1; s_dat_i = 32'hDEADBEEF;
    #1;
    check("sr_ack", m_ack, 4'b0100);
    check("sr_dat", m_dat, 32'hDEADBEEF);
    tick();
    s_ack = 1'b0; cyc = '0; stb = '0;
    #1;
    check("sr_ack_once", m_ack, 0);
    tick();

    // Watchdog: slave never terminates
    cyc = 4'b0010; stb = 4'b0010;
    tick();
    saw = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (!s_cyc || tmo || m_ack != 0 || m_err != 0) saw = 1'b1;
      tick();
    end
    check("wd_pre_abort", saw, 0);
    check("wd_cyc", s_cyc, 0);
    check("wd_stb", s_stb, 0);
    check("wd_err", m_err, 4'b0010);
    check("wd_tmo", tmo, 1);
    s_ack = 1'b1;
    #1;
    check("wd_ack_ignored", m_ack, 0);
    s_ack = 1'b0;
    tick();
    check("wd_tmo_end", tmo, 0);
    check("wd_err_end", m_err, 0);
    check("wd_resume", s_cyc, 1);
    cyc = '0; stb = '0;
    tick();

    // Race: ack in the limit cycle beats the abort
    cyc = 4'b1000; stb = 4'b1000;
    tick();
    repeat (7) tick();
    s_ack = 1'b1;
    #1;
    check("rc_ack", m_ack, 4'b1000);
    check("rc_tmo", tmo, 0);
    tick();
    s_ack = 1'b0;
    #1;
    check("rc_tmo_after", tmo, 0);
    check("rc_err_after", m_err, 0);
    check("rc_cyc", s_cyc, 1);
    cyc = '0; stb = '0;
    tick();

    // Termination pass-through on port 0
    cyc = 4'b0001; stb = 4'b0001;
    tick();
    for (int i = 0; i < 5; i++) begin
      {s_rty, s_err, s_ack} = t_vecs[i].term;
      #1;
      check("term_ack", m_ack, t_vecs[i].ack);
      check("term_err", m_err, t_vecs[i].err);
      check("term_rty", m_rty, t_vecs[i].rty);
      tick();
    end
    {s_rty, s_err, s_ack} = 3'b000;
    cyc = '0; stb = '0;
    tick();

    // Async reset mid-access on port 2
    cyc = 4'b0100; stb = 4'b0100;
    tick();
    s_ack = 1'b1;
    #1;
    check("ar_ack_pre", m_ack, 4'b0100);
    #1 rst = 1'b1;
    #1;
    check("ar_cyc", s_cyc, 0);
    check("ar_gnt", gnt, 0);
    check("ar_ack", m_ack, 0);
    check("ar_err", m_err, 0);
    s_ack = 1'b0; cyc = '0; stb = '0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    cyc = 4'b1111; stb = 4'b1111;
    tick();
    check("ar_port0_first", gnt, 4'b0001);
    cyc = '0; stb = '0;
    tick();
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
